// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive D grants taken while I was waiting; raises force_i at the limit.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic grant,
  input  logic owner,
  input  logic i_req,
  output logic force_i
);

  localparam int unsigned SatW = $clog2(STARVE_MAX + 1);

  logic [SatW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (grant) begin
      if (owner == OwnerD && i_req) begin
        if (cnt_q != SatW'(STARVE_MAX)) cnt_q <= cnt_q + SatW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign force_i = (cnt_q == SatW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants a shared single-port memory to fetch (I) or data (D) and sequences the
// fixed-latency access, returning a one-cycle ack to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_sel,
  output logic          mem_en,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MEM_LAT) + 1;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            sel_q;
  logic            issue;
  logic            grant_d;
  logic            force_i;

  // Address and write data are muxed externally on mem_sel.
  logic unused_mux_inputs;
  assign unused_mux_inputs = ^{i_addr, d_addr, d_wdata};

  // rstn gates the issue so nothing is strobed while reset is held.
  assign issue   = rstn && (state_q == StIdle) && (i_req || d_req);
  assign grant_d = d_req && !(force_i && i_req);

  assign mem_en  = issue;
  assign mem_sel = issue ? grant_d : sel_q;
  assign mem_we  = issue && grant_d && d_we;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rstn   (rstn),
    .grant  (issue),
    .owner  (grant_d),
    .i_req  (i_req),
    .force_i(force_i)
  );

  // cnt_q holds the cycles left until the memory output is valid; RESP is
  // entered on the cycle it would reach zero, so ack lands at issue + MEM_LAT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= OwnerI;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            sel_q <= grant_d;
            cnt_q <= CntW'(MEM_LAT - 1);
            if (MEM_LAT == 1) begin
              state_q <= StResp;
              i_ack   <= (grant_d == OwnerI);
              d_ack   <= (grant_d == OwnerD);
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StResp;
            i_ack   <= (sel_q == OwnerI);
            d_ack   <= (sel_q == OwnerD);
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Observed activity logs, appended by the checker process only.
  int   issue_cyc[$];
  logic issue_own[$];
  logic issue_we[$];
  int   iack_cyc[$];
  int   dack_cyc[$];

  mem_port_arbiter #(
    .AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory environment: external 2:1 mux on mem_sel plus a LAT-deep read pipe.
  logic [31:0] env_mem [256];
  bit          env_wr  [256];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk);
      a = mem_sel ? d_addr : i_addr;
      for (int k = LAT - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
      if (mem_en && mem_we) begin
        env_mem[a[9:2]] = d_wdata;
        env_wr[a[9:2]]  = 1'b1;
      end else if (mem_en) begin
        rd_pipe[0] = env_wr[a[9:2]] ? env_mem[a[9:2]] : init_val(a);
      end
    end
  end

  // Reference model: one access per LAT+1 cycles, D first unless I has been
  // passed over SMAX times in a row; checked on every falling edge.
  logic [31:0] ref_mem [256];
  bit          ref_wr  [256];

  initial begin
    int          ack_at;
    int          next_free;
    int          starve;
    logic        ack_own;
    logic        ack_rd;
    logic        last_sel;
    logic [31:0] exp_rd;
    logic [31:0] a;
    logic        own;
    logic        e_en, e_sel, e_we, e_iack, e_dack;
    logic        prev_i_pend, prev_d_pend;
    ack_at = -1; next_free = 0; starve = 0; last_sel = 1'b0;
    ack_own = 1'b0; ack_rd = 1'b0; exp_rd = '0;
    prev_i_pend = 1'b0; prev_d_pend = 1'b0;
    forever begin
      @(negedge clk);
      e_en = 1'b0; e_sel = 1'b0; e_we = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
      if (!rstn) begin
        ack_at = -1; next_free = 0; starve = 0; last_sel = 1'b0;
        prev_i_pend = 1'b0; prev_d_pend = 1'b0;
      end else begin
        e_iack = (cyc == ack_at) && !ack_own;
        e_dack = (cyc == ack_at) && ack_own;
        e_sel  = last_sel;
        if (cyc >= next_free && (i_req || d_req)) begin
          own   = d_req && !(i_req && starve == SMAX);
          e_en  = 1'b1;
          e_sel = own;
          e_we  = own && d_we;
          if (own && i_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
          else starve = 0;
          a = own ? d_addr : i_addr;
          if (e_we) begin
            ref_mem[a[9:2]] = d_wdata;
            ref_wr[a[9:2]]  = 1'b1;
          end else begin
            exp_rd = ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_val(a);
          end
          ack_at = cyc + LAT; ack_own = own; ack_rd = !e_we;
          next_free = cyc + LAT + 1; last_sel = own;
        end
        if (prev_i_pend) chk("i_req_held", {31'b0, i_req}, 32'd1);
        if (prev_d_pend) chk("d_req_held", {31'b0, d_req}, 32'd1);
        prev_i_pend = i_req && !i_ack;
        prev_d_pend = d_req && !d_ack;
      end
      chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      chk("mem_sel", {31'b0, mem_sel}, {31'b0, e_sel});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("i_ack", {31'b0, i_ack}, {31'b0, e_iack});
      chk("d_ack", {31'b0, d_ack}, {31'b0, e_dack});
      if (e_iack) chk("i_rdata", i_rdata, exp_rd);
      if (e_dack && ack_rd) chk("d_rdata", d_rdata, exp_rd);
      if (mem_en) begin
        issue_cyc.push_back(cyc); issue_own.push_back(mem_sel); issue_we.push_back(mem_we);
      end
      if (i_ack) iack_cyc.push_back(cyc);
      if (d_ack) dack_cyc.push_back(cyc);
    end
  end

  task automatic wait_ack(input bit is_d, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        rd  = is_d ? d_rdata : i_rdata;
        break;
      end
    end
    if (!got) chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] rd);
    i_addr = a;
    i_req  = 1'b1;
    wait_ack(1'b0, rd);
    i_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input bit keep, output logic [31:0] rd);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    wait_ack(1'b1, rd);
    if (!keep) d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_i, rd_d;
    int bi, ba, bd;

    // 1: reset held with both requests asserted
    i_req = 1'b1; d_req = 1'b1;
    repeat (5) @(posedge clk);
    chk("reset_no_issue", issue_cyc.size(), 32'd0);
    #1;
    i_req = 1'b0; d_req = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;

    // 2: single fetch
    bi = issue_cyc.size(); ba = iack_cyc.size();
    fetch(32'h100, rd_i);
    chk("fetch_rdata", rd_i, 32'hCAFE_0100);
    chk("fetch_sel", {31'b0, issue_own[bi]}, 32'd0);
    chk("fetch_lat", iack_cyc[ba] - issue_cyc[bi], 32'd2);

    // 3: simultaneous requests, D first
    bi = issue_cyc.size(); ba = iack_cyc.size(); bd = dack_cyc.size();
    fork
      fetch(32'h104, rd_i);
      dacc(1'b0, 32'h200, 32'h0, 1'b0, rd_d);
    join
    chk("conf_first_d", {31'b0, issue_own[bi]}, 32'd1);
    chk("conf_dack", dack_cyc[bd] - issue_cyc[bi], 32'd2);
    chk("conf_i_issue", issue_cyc[bi+1] - issue_cyc[bi], 32'd3);
    chk("conf_iack", iack_cyc[ba] - issue_cyc[bi], 32'd5);
    chk("conf_drdata", rd_d, 32'hCAFE_0200);
    chk("conf_irdata", rd_i, 32'hCAFE_0104);

    // 4: D held continuously; I forced after three D grants
    bi = issue_cyc.size();
    fork
      for (int k = 0; k < 4; k++) dacc(1'b0, 32'h300 + 32'(4 * k), 32'h0, k < 3, rd_d);
      fetch(32'h108, rd_i);
    join
    chk("starve_g0", {31'b0, issue_own[bi]}, 32'd1);
    chk("starve_g1", {31'b0, issue_own[bi+1]}, 32'd1);
    chk("starve_g2", {31'b0, issue_own[bi+2]}, 32'd1);
    chk("starve_g3", {31'b0, issue_own[bi+3]}, 32'd0);
    chk("starve_i_cyc", issue_cyc[bi+3] - issue_cyc[bi], 32'd9);
    chk("starve_cnt", {30'b0, u_dut.u_starve.cnt_q}, 32'd0);

    // 5: write then read back
    bi = issue_cyc.size(); bd = dack_cyc.size();
    dacc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, rd_d);
    chk("wr_we", {31'b0, issue_we[bi]}, 32'd1);
    chk("wr_lat", dack_cyc[bd] - issue_cyc[bi], 32'd2);
    dacc(1'b0, 32'h40, 32'h0, 1'b0, rd_d);
    chk("wr_readback", rd_d, 32'hDEAD_BEEF);

    // 6: reset during WAIT drops the access without an ack
    bi = issue_cyc.size(); ba = iack_cyc.size();
    i_addr = 32'h180; i_req = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0; i_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_issued", issue_cyc.size() - bi, 32'd1);
    chk("rst_no_ack", iack_cyc.size() - ba, 32'd0);
    fetch(32'h180, rd_i);
    chk("rst_refetch", rd_i, 32'hCAFE_0180);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
